io_ports: RTL and testbench

- Memory-mapped I/O responder serving the CPU's IN/OUT instructions.
- The datapath acts as initiator: it drives the port address, the read/write strobes and the write data from a register operand. It consumes the read data into the register file write-back path in the same cycle.
- This block answers those accesses through four ports:
  - a buffered output stream (TX FIFO, valid/ready to an external device);
  - a buffered input stream (RX FIFO);
  - a status/control register;
  - an 8-bit parallel GPIO latch.
- It also produces a level interrupt request.

---
 rtl/io_ports.sv | 126 ++++++++++++
 tb/tb_io_ports.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/io_ports.sv
// CPU IN/OUT responder: TX/RX byte FIFOs, status/control register, GPIO latch, level IRQ.
// FIFO storage is read combinationally so the CPU sees read data in the same cycle.
module io_ports #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] io_addr,
  input  logic       io_we,
  input  logic       io_re,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]  r_tx_mem [DEPTH];
  logic [7:0]  r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [AW:0] r_tx_cnt, r_rx_cnt;
  logic        r_ie_rx, r_ie_tx, r_txovf, r_rxunf;
  logic [7:0]  r_gpio;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_req, w_tx_push, w_tx_pop, w_txovf_set;
  logic w_rx_rd, w_rx_push, w_rx_pop, w_rxunf_set;
  logic w_ctrl_we, w_gpio_we;
  logic [7:0] w_status;

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);

  assign tx_valid = !w_tx_empty;
  assign tx_data  = r_tx_mem[r_tx_rd];
  assign rx_ready = !w_rx_full;
  assign gpio_out = r_gpio;
  assign irq      = (r_ie_rx && !w_rx_empty) || (r_ie_tx && w_tx_empty);

  // A full TX FIFO still accepts a write when the sink drains an entry on the same edge.
  assign w_tx_pop    = tx_valid && tx_ready;
  assign w_tx_req    = io_we && (io_addr == 2'd0);
  assign w_tx_push   = w_tx_req && (!w_tx_full || w_tx_pop);
  assign w_txovf_set = w_tx_req && !w_tx_push;

  assign w_rx_push   = rx_valid && rx_ready;
  assign w_rx_rd     = io_re && (io_addr == 2'd1);
  assign w_rx_pop    = w_rx_rd && !w_rx_empty;
  assign w_rxunf_set = w_rx_rd && w_rx_empty;

  assign w_ctrl_we = io_we && (io_addr == 2'd2);
  assign w_gpio_we = io_we && (io_addr == 2'd3);

  assign w_status = {irq, r_ie_rx, r_rxunf, r_txovf, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

  always_comb begin
    io_rdata = 8'h00;
    if (io_re) begin
      case (io_addr)
        2'd1:    if (!w_rx_empty) io_rdata = r_rx_mem[r_rx_rd];
        2'd2:    io_rdata = w_status;
        2'd3:    io_rdata = gpio_in;
        default: io_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= io_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
      r_ie_rx  <= 1'b0;
      r_ie_tx  <= 1'b0;
      r_txovf  <= 1'b0;
      r_rxunf  <= 1'b0;
      r_gpio   <= 8'h00;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase

      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase

      if (w_ctrl_we) begin
        r_ie_rx <= io_wdata[0];
        r_ie_tx <= io_wdata[1];
      end
      // Setting a sticky flag overrides a write-1-to-clear on the same edge.
      r_txovf <= w_txovf_set | (r_txovf & ~(w_ctrl_we & io_wdata[4]));
      r_rxunf <= w_rxunf_set | (r_rxunf & ~(w_ctrl_we & io_wdata[5]));

      if (w_gpio_we) r_gpio <= io_wdata;
    end
  end

endmodule

// File: tb/tb_io_ports.sv
// Directed bench for io_ports: TX/RX streaming, overflow/underflow flags, IRQ and GPIO.
module tb_io_ports;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] io_addr;
  logic       io_we, io_re;
  logic [7:0] io_wdata, io_rdata;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] gpio_in, gpio_out;
  logic       irq;

  int n_err = 0;
  int n_chk = 0;

  io_ports #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
    .io_wdata(io_wdata), .io_rdata(io_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end else begin
      $display("ok   %s: %02h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    io_we = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    io_re = 1'b1; io_addr = a;
    #1;
    d = io_rdata;
    tick();
    io_re = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    tick();
    rx_valid = 1'b0;
  endtask

  logic [7:0] rd;
  logic [7:0] v4 [4];

  initial begin
    reset = 1'b1; io_addr = 2'd0; io_we = 1'b0; io_re = 1'b0; io_wdata = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; gpio_in = 8'h00;
    tick(); tick();
    reset = 1'b0;
    check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_gpio_out", gpio_out, 8'h00);

    // TX stream held, then drained in order
    cpu_wr(2'd0, 8'h11); cpu_wr(2'd0, 8'h22); cpu_wr(2'd0, 8'h33);
    check("tx_valid_held", {7'd0, tx_valid}, 8'h01);
    check("tx_head_held", tx_data, 8'h11);
    tick();
    check("tx_head_stable", tx_data, 8'h11);
    tx_ready = 1'b1;
    #1;
    check("tx_out0", tx_data, 8'h11);
    tick(); check("tx_out1", tx_data, 8'h22);
    tick(); check("tx_out2", tx_data, 8'h33);
    tick(); check("tx_drained", {7'd0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // Overflow: 5th write dropped
    for (int i = 1; i <= 5; i++) cpu_wr(2'd0, 8'(i));
    cpu_rd(2'd2, rd); check("status_full_ovf", rd, 8'h15);
    tx_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_out%0d", i), tx_data, 8'(i));
      tick();
    end
    check("ovf_drained", {7'd0, tx_valid}, 8'h00);
    tx_ready = 1'b0;
    cpu_wr(2'd2, 8'h10);
    cpu_rd(2'd2, rd); check("status_ovf_clr", rd, 8'h06);

    // RX fill, drain and underflow
    v4 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rx_ready_%0d", i), {7'd0, rx_ready}, 8'h01);
      rx_push(v4[i]);
    end
    check("rx_ready_full", {7'd0, rx_ready}, 8'h00);
    cpu_rd(2'd2, rd); check("status_rx_full", rd, 8'h0A);
    for (int i = 0; i < 4; i++) begin
      cpu_rd(2'd1, rd); check($sformatf("rx_rd%0d", i), rd, v4[i]);
    end
    cpu_rd(2'd1, rd); check("rx_rd_empty", rd, 8'h00);
    cpu_rd(2'd2, rd); check("status_unf", rd, 8'h26);
    cpu_wr(2'd2, 8'h30);
    cpu_rd(2'd2, rd); check("status_unf_clr", rd, 8'h06);

    // Write into full TX while it drains: accepted
    for (int i = 0; i < 4; i++) cpu_wr(2'd0, 8'h10 + 8'(i));
    tx_ready = 1'b1;
    #1;
    check("fullpop_head", tx_data, 8'h10);
    cpu_wr(2'd0, 8'h44);
    check("fullpop_o1", tx_data, 8'h11);
    tick(); check("fullpop_o2", tx_data, 8'h12);
    tick(); check("fullpop_o3", tx_data, 8'h13);
    tick(); check("fullpop_o4", tx_data, 8'h44);
    tick(); check("fullpop_drained", {7'd0, tx_valid}, 8'h00);
    tx_ready = 1'b0;
    cpu_rd(2'd2, rd); check("fullpop_no_ovf", rd, 8'h06);

    // Interrupts
    cpu_wr(2'd2, 8'h03);
    check("irq_tx_empty", {7'd0, irq}, 8'h01);
    cpu_rd(2'd2, rd); check("status_ie_irq", rd, 8'hC6);
    cpu_wr(2'd0, 8'h55);
    check("irq_tx_busy", {7'd0, irq}, 8'h00);
    rx_push(8'h77);
    check("irq_rx_data", {7'd0, irq}, 8'h01);
    cpu_rd(2'd1, rd); check("rx_irq_byte", rd, 8'h77);
    check("irq_rx_drained", {7'd0, irq}, 8'h00);

    // GPIO, addr 0 read, reset mid-stream
    gpio_in = 8'h5A;
    cpu_rd(2'd3, rd); check("gpio_in", rd, 8'h5A);
    cpu_rd(2'd0, rd); check("rd_addr0", rd, 8'h00);
    cpu_wr(2'd3, 8'hC3);
    check("gpio_out", gpio_out, 8'hC3);
    for (int i = 0; i < 4; i++) rx_push(8'hB0 + 8'(i));
    check("pre_rst_rx_ready", {7'd0, rx_ready}, 8'h00);
    check("pre_rst_tx_valid", {7'd0, tx_valid}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_gpio", gpio_out, 8'h00);
    check("mid_rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("mid_rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    check("mid_rst_irq", {7'd0, irq}, 8'h00);
    cpu_rd(2'd2, rd); check("mid_rst_status", rd, 8'h06);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
